// File: rtl/centroid_frame_ctrl.sv
// Frame sequencer for calc_centroid: row/column tracking, bottom-ROI forwarding,
// divider drain, per-frame centroid capture with line-loss debounce and a valid/ready result.
module centroid_frame_ctrl #(
  parameter int unsigned IMG_W       = 640,
  parameter int unsigned IMG_H       = 480,
  parameter int unsigned ROI_HEIGHT  = 32,
  parameter int unsigned THRESHOLD   = 0,
  parameter int unsigned DIV_LATENCY = 6,
  parameter int unsigned LOST_FRAMES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [3:0]  pix_in,
  output logic        cc_clear,
  output logic        cc_in_ready,
  output logic [3:0]  cc_pixel,
  input  logic [10:0] cc_centroid_x,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [10:0] res_x,
  output logic        res_lost,
  output logic [7:0]  res_frame_id,
  output logic        overrun,
  output logic        sync_err,
  output logic        busy
);

  localparam int unsigned XW            = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW            = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned DW            = $clog2(DIV_LATENCY + 2);
  localparam int unsigned MW            = $clog2(LOST_FRAMES + 1);
  localparam int unsigned SKIP_ROWS     = IMG_H - ROI_HEIGHT;
  localparam int unsigned LAST_SKIP_ROW = (SKIP_ROWS > 0) ? SKIP_ROWS - 1 : 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SKIP    = 3'd1,
    ST_ROI     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_CAPTURE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_cnt_q, x_cnt_d;
  logic [YW-1:0] y_cnt_q, y_cnt_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic [MW-1:0] miss_cnt_q, miss_cnt_d;
  logic          frame_hit_q, frame_hit_d;
  logic          cc_clear_q, cc_clear_d;
  logic          cc_in_ready_q, cc_in_ready_d;
  logic [3:0]    cc_pixel_q, cc_pixel_d;
  logic          res_valid_q, res_valid_d;
  logic [10:0]   res_x_q, res_x_d;
  logic          res_lost_q, res_lost_d;
  logic [7:0]    res_frame_id_q, res_frame_id_d;
  logic          overrun_q, overrun_d;
  logic          sync_err_q, sync_err_d;
  logic          busy_q, busy_d;

  // Raster position decode and next position for an accepted pixel
  logic          row_end_c;
  logic          skip_end_c;
  logic          frame_end_c;
  logic [XW-1:0] x_inc_c;
  logic [YW-1:0] y_inc_c;

  assign row_end_c   = (x_cnt_q == XW'(IMG_W - 1));
  assign skip_end_c  = row_end_c && (y_cnt_q == YW'(LAST_SKIP_ROW));
  assign frame_end_c = row_end_c && (y_cnt_q == YW'(IMG_H - 1));
  assign x_inc_c     = row_end_c ? '0 : x_cnt_q + XW'(1);
  assign y_inc_c     = row_end_c ? y_cnt_q + YW'(1) : y_cnt_q;

  // Next-state, counters and registered outputs
  always_comb begin
    state_d        = state_q;
    x_cnt_d        = x_cnt_q;
    y_cnt_d        = y_cnt_q;
    drain_cnt_d    = drain_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    frame_hit_d    = frame_hit_q;
    cc_clear_d     = 1'b0;
    cc_in_ready_d  = 1'b0;
    cc_pixel_d     = cc_pixel_q;
    res_valid_d    = res_valid_q && !res_ready;
    res_x_d        = res_x_q;
    res_lost_d     = res_lost_q;
    res_frame_id_d = res_frame_id_q;
    overrun_d      = 1'b0;
    sync_err_d     = (frame_start && (state_q != ST_IDLE)) ||
                     (pix_valid && ((state_q == ST_IDLE) || (state_q == ST_DRAIN) ||
                                    (state_q == ST_CAPTURE)));

    if (frame_start) begin
      // A frame_start in any state (re)starts a frame; an in-flight frame is dropped
      cc_clear_d  = 1'b1;
      x_cnt_d     = '0;
      y_cnt_d     = '0;
      drain_cnt_d = '0;
      frame_hit_d = 1'b0;
      state_d     = (SKIP_ROWS == 0) ? ST_ROI : ST_SKIP;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_SKIP: begin
          if (pix_valid) begin
            x_cnt_d = x_inc_c;
            y_cnt_d = y_inc_c;
            if (skip_end_c) state_d = ST_ROI;
          end
        end
        ST_ROI: begin
          cc_in_ready_d = pix_valid;
          if (pix_valid) begin
            cc_pixel_d = pix_in;
            x_cnt_d    = x_inc_c;
            y_cnt_d    = y_inc_c;
            if (pix_in > 4'(THRESHOLD)) frame_hit_d = 1'b1;
            if (frame_end_c) begin
              drain_cnt_d = '0;
              state_d     = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == DW'(DIV_LATENCY + 1)) state_d = ST_CAPTURE;
          else                                     drain_cnt_d = drain_cnt_q + DW'(1);
        end
        ST_CAPTURE: begin
          state_d        = ST_IDLE;
          res_valid_d    = 1'b1;
          res_frame_id_d = res_frame_id_q + 8'd1;
          overrun_d      = res_valid_q && !res_ready;
          if (frame_hit_q) begin
            miss_cnt_d = '0;
            res_x_d    = cc_centroid_x;
          end else if (miss_cnt_q != MW'(LOST_FRAMES)) begin
            miss_cnt_d = miss_cnt_q + MW'(1);
          end
          res_lost_d = (miss_cnt_d == MW'(LOST_FRAMES));
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      x_cnt_q        <= '0;
      y_cnt_q        <= '0;
      drain_cnt_q    <= '0;
      miss_cnt_q     <= '0;
      frame_hit_q    <= 1'b0;
      cc_clear_q     <= 1'b1;
      cc_in_ready_q  <= 1'b0;
      cc_pixel_q     <= '0;
      res_valid_q    <= 1'b0;
      res_x_q        <= '0;
      res_lost_q     <= 1'b0;
      res_frame_id_q <= '0;
      overrun_q      <= 1'b0;
      sync_err_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_cnt_q        <= x_cnt_d;
      y_cnt_q        <= y_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
      frame_hit_q    <= frame_hit_d;
      cc_clear_q     <= cc_clear_d;
      cc_in_ready_q  <= cc_in_ready_d;
      cc_pixel_q     <= cc_pixel_d;
      res_valid_q    <= res_valid_d;
      res_x_q        <= res_x_d;
      res_lost_q     <= res_lost_d;
      res_frame_id_q <= res_frame_id_d;
      overrun_q      <= overrun_d;
      sync_err_q     <= sync_err_d;
      busy_q         <= busy_d;
    end
  end

  assign cc_clear     = cc_clear_q;
  assign cc_in_ready  = cc_in_ready_q;
  assign cc_pixel     = cc_pixel_q;
  assign res_valid    = res_valid_q;
  assign res_x        = res_x_q;
  assign res_lost     = res_lost_q;
  assign res_frame_id = res_frame_id_q;
  assign overrun      = overrun_q;
  assign sync_err     = sync_err_q;
  assign busy         = busy_q;

endmodule
